// File: rtl/wb_splitter_if.sv
// wb_splitter_if: bundle of the upstream (s_*) and per-target downstream (m_*)
// bus signals of the Wishbone-style splitter.
//   slave  modport: the splitter's view (takes upstream requests and target
//                   responses, drives upstream response and target requests).
//   master modport: the environment's view (initiator plus targets).
interface wb_splitter_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 16,
  parameter int MW = DW / 8
);
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_rdata;
  logic [DW-1:0]   s_wdata;
  logic [MW-1:0]   s_wmsk;
  logic            s_we;
  logic            s_cyc;
  logic            s_ack;
  logic            s_err;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [MW-1:0]   m_wmsk;
  logic            m_we;
  logic [N-1:0]    m_cyc;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ack;

  modport slave (
    input  s_addr, s_wdata, s_wmsk, s_we, s_cyc, m_rdata, m_ack,
    output s_rdata, s_ack, s_err, m_addr, m_wdata, m_wmsk, m_we, m_cyc
  );

  modport master (
    output s_addr, s_wdata, s_wmsk, s_we, s_cyc, m_rdata, m_ack,
    input  s_rdata, s_ack, s_err, m_addr, m_wdata, m_wmsk, m_we, m_cyc
  );
endinterface

// File: rtl/wb_splitter.sv
// wb_splitter: single-initiator to N-target bus splitter.
// Decodes s_addr[AW-1 -: SW] as the target index, presents a registered request
// on m_cyc[idx] and the broadcast m_* fields, and returns the target's data as a
// one-cycle registered s_ack. Unmapped indices and targets that stay silent for
// TO busy cycles are terminated with s_err=1 and s_rdata=ERR_DATA.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - wb_splitter_if.slave (upstream s_* and downstream m_* signals)
module wb_splitter #(
  parameter int          N        = 4,
  parameter int          DW       = 32,
  parameter int          AW       = 16,
  parameter int          MW       = DW / 8,
  parameter int          SW       = 2,
  parameter int          TO       = 255,
  parameter logic [DW-1:0] ERR_DATA = '1
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_splitter_if.slave   bus
);

  localparam int CW = $clog2(TO + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [SW-1:0] idx_q,     idx_d;
  logic [N-1:0]  m_cyc_q,   m_cyc_d;
  logic [AW-1:0] m_addr_q,  m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [MW-1:0] m_wmsk_q,  m_wmsk_d;
  logic          m_we_q,    m_we_d;
  logic [DW-1:0] s_rdata_q, s_rdata_d;
  logic          s_ack_q,   s_ack_d;
  logic          s_err_q,   s_err_d;

  logic [SW-1:0] s_idx;
  logic          mapped;
  logic          ack_sel;
  logic [DW-1:0] rd_sel;

  assign s_idx  = bus.s_addr[AW-1 -: SW];
  assign mapped = (32'(s_idx) < 32'(N));

  // Response mux over the latched index; acks from other targets never reach it.
  always_comb begin
    ack_sel = 1'b0;
    rd_sel  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == SW'(k)) begin
        ack_sel = bus.m_ack[k];
        rd_sel  = bus.m_rdata[DW*k +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    m_cyc_d   = m_cyc_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmsk_d  = m_wmsk_q;
    m_we_d    = m_we_q;
    // Upstream response is non-zero only while in ACK, so it can be OR-combined.
    s_rdata_d = '0;
    s_ack_d   = 1'b0;
    s_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_cyc) begin
          m_addr_d  = bus.s_addr;
          m_wdata_d = bus.s_wdata;
          m_wmsk_d  = bus.s_wmsk;
          m_we_d    = bus.s_we;
          idx_d     = s_idx;
          if (mapped) begin
            for (int unsigned k = 0; k < N; k++) begin
              m_cyc_d[k] = (s_idx == SW'(k));
            end
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            s_rdata_d = ERR_DATA;
            s_ack_d   = 1'b1;
            s_err_d   = 1'b1;
            state_d   = ACK;
          end
        end
      end
      BUSY: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (ack_sel) begin
          m_cyc_d   = '0;
          s_rdata_d = rd_sel;
          s_ack_d   = 1'b1;
          state_d   = ACK;
        end else if (cnt_q == CW'(TO - 1)) begin
          m_cyc_d   = '0;
          s_rdata_d = ERR_DATA;
          s_ack_d   = 1'b1;
          s_err_d   = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_cyc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      m_cyc_q   <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmsk_q  <= '0;
      m_we_q    <= 1'b0;
      s_rdata_q <= '0;
      s_ack_q   <= 1'b0;
      s_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      m_cyc_q   <= m_cyc_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmsk_q  <= m_wmsk_d;
      m_we_q    <= m_we_d;
      s_rdata_q <= s_rdata_d;
      s_ack_q   <= s_ack_d;
      s_err_q   <= s_err_d;
    end
  end

  assign bus.s_rdata = s_rdata_q;
  assign bus.s_ack   = s_ack_q;
  assign bus.s_err   = s_err_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wmsk  = m_wmsk_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_cyc   = m_cyc_q;

endmodule

// File: tb/tb_wb_splitter.sv
// Directed bench for wb_splitter: a 4-target instance (TO=8) and a 3-target
// instance (TO=8) share one clock; inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
module tb_wb_splitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic b3_cyc_seen = 1'b0;

  always #5 clk = ~clk;

  wb_splitter_if #(.N(4), .DW(32), .AW(16)) b4 ();
  wb_splitter_if #(.N(3), .DW(32), .AW(16)) b3 ();

  wb_splitter #(.N(4), .DW(32), .AW(16), .SW(2), .TO(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );
  wb_splitter #(.N(3), .DW(32), .AW(16), .SW(2), .TO(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  always @(posedge clk) if (b3.m_cyc !== 3'b000) b3_cyc_seen <= 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    b4.s_addr = '0; b4.s_wdata = '0; b4.s_wmsk = '0; b4.s_we = 1'b0; b4.s_cyc = 1'b0;
    b4.m_rdata = '0; b4.m_ack = '0;
    b3.s_addr = '0; b3.s_wdata = '0; b3.s_wmsk = '0; b3.s_we = 1'b0; b3.s_cyc = 1'b0;
    b3.m_rdata = '0; b3.m_ack = '0;

    // Reset state
    #2;
    chk("rst_s_ack", 64'(b4.s_ack), 64'h0);
    chk("rst_m_cyc", 64'(b4.m_cyc), 64'h0);
    chk("rst_s_rdata", 64'(b4.s_rdata), 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Read target 2, ack one cycle after m_cyc
    b4.s_addr = 16'h8004; b4.s_we = 1'b0; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    chk("rd2_m_cyc", 64'(b4.m_cyc), 64'h4);
    chk("rd2_m_addr", 64'(b4.m_addr), 64'h8004);
    chk("rd2_no_ack_t1", 64'(b4.s_ack), 64'h0);
    tick();                                            // t+2
    b4.m_ack = 4'b0100; b4.m_rdata[64 +: 32] = 32'h12345678;
    tick();                                            // t+3
    chk("rd2_s_ack", 64'(b4.s_ack), 64'h1);
    chk("rd2_s_rdata", 64'(b4.s_rdata), 64'h12345678);
    chk("rd2_s_err", 64'(b4.s_err), 64'h0);
    chk("rd2_m_cyc_low", 64'(b4.m_cyc), 64'h0);
    b4.m_ack = '0; b4.s_cyc = 1'b0;
    tick();
    chk("rd2_ack_pulse", 64'(b4.s_ack), 64'h0);
    chk("rd2_rdata_zero", 64'(b4.s_rdata), 64'h0);

    // Write to target 0, immediate ack
    b4.s_addr = 16'h0010; b4.s_wdata = 32'hA5A5A5A5; b4.s_wmsk = 4'b0011;
    b4.s_we = 1'b1; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    chk("wr0_m_we", 64'(b4.m_we), 64'h1);
    chk("wr0_m_wdata", 64'(b4.m_wdata), 64'hA5A5A5A5);
    chk("wr0_m_wmsk", 64'(b4.m_wmsk), 64'h3);
    chk("wr0_m_cyc", 64'(b4.m_cyc), 64'h1);
    b4.m_ack = 4'b0001;
    tick();                                            // t+2
    chk("wr0_s_ack", 64'(b4.s_ack), 64'h1);
    chk("wr0_s_err", 64'(b4.s_err), 64'h0);
    b4.m_ack = '0; b4.s_cyc = 1'b0; b4.s_we = 1'b0;
    tick();
    chk("wr0_fields_hold", 64'(b4.m_wdata), 64'hA5A5A5A5);

    // Unmapped index 3 on the 3-target instance
    b3.s_addr = 16'hC000; b3.s_cyc = 1'b1;
    tick();                                            // t+1
    chk("um_s_ack", 64'(b3.s_ack), 64'h1);
    chk("um_s_err", 64'(b3.s_err), 64'h1);
    chk("um_s_rdata", 64'(b3.s_rdata), 64'hFFFFFFFF);
    b3.s_cyc = 1'b0;
    tick();
    chk("um_ack_pulse", 64'(b3.s_ack), 64'h0);
    chk("um_err_clear", 64'(b3.s_err), 64'h0);

    // Timeout: target 1 never acks
    b4.s_addr = 16'h4000; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    hi = 0;
    for (int k = 1; k <= 8; k++) begin
      if (b4.m_cyc === 4'b0010 && b4.s_ack === 1'b0) hi++;
      tick();
    end                                                // now t+9
    chk("to_cyc_cycles", 64'(hi), 64'd8);
    chk("to_m_cyc_low", 64'(b4.m_cyc), 64'h0);
    chk("to_s_ack", 64'(b4.s_ack), 64'h1);
    chk("to_s_err", 64'(b4.s_err), 64'h1);
    chk("to_s_rdata", 64'(b4.s_rdata), 64'hFFFFFFFF);
    b4.s_cyc = 1'b0;
    tick();

    // Ack in the expiry cycle wins
    b4.s_addr = 16'h4008; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    repeat (7) tick();                                 // t+8
    chk("exp_m_cyc", 64'(b4.m_cyc), 64'h2);
    b4.m_ack = 4'b0010; b4.m_rdata[32 +: 32] = 32'hCAFEF00D;
    tick();                                            // t+9
    chk("exp_s_ack", 64'(b4.s_ack), 64'h1);
    chk("exp_s_err", 64'(b4.s_err), 64'h0);
    chk("exp_s_rdata", 64'(b4.s_rdata), 64'hCAFEF00D);
    b4.m_ack = '0; b4.s_cyc = 1'b0;
    tick();

    // Spurious ack from target 3 while target 1 is busy
    b4.s_addr = 16'h4000; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    b4.m_ack = 4'b1000; b4.m_rdata[96 +: 32] = 32'h0BAD0BAD;
    tick();                                            // t+2
    chk("sp_no_ack", 64'(b4.s_ack), 64'h0);
    chk("sp_m_cyc", 64'(b4.m_cyc), 64'h2);
    b4.m_ack = 4'b0010; b4.m_rdata[32 +: 32] = 32'h11111111;
    tick();                                            // t+3
    chk("sp_s_rdata", 64'(b4.s_rdata), 64'h11111111);
    chk("sp_s_ack", 64'(b4.s_ack), 64'h1);
    b4.m_ack = '0; b4.s_cyc = 1'b0;
    tick();

    // Back-to-back reads: target 0 then target 1, s_cyc held high
    b4.s_addr = 16'h0020; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    b4.m_ack = 4'b0001; b4.m_rdata[0 +: 32] = 32'hAAAA0001;
    tick();                                            // t+2 (ACK)
    chk("b2b_first_data", 64'(b4.s_rdata), 64'hAAAA0001);
    chk("b2b_first_ack", 64'(b4.s_ack), 64'h1);
    b4.m_ack = '0; b4.s_addr = 16'h4020;
    tick();                                            // IDLE samples s_cyc
    chk("b2b_idle_no_ack", 64'(b4.s_ack), 64'h0);
    tick();
    chk("b2b_second_m_cyc", 64'(b4.m_cyc), 64'h2);
    chk("b2b_second_m_addr", 64'(b4.m_addr), 64'h4020);
    b4.m_ack = 4'b0010; b4.m_rdata[32 +: 32] = 32'hBBBB0002;
    tick();
    chk("b2b_second_data", 64'(b4.s_rdata), 64'hBBBB0002);
    chk("b2b_second_ack", 64'(b4.s_ack), 64'h1);
    b4.m_ack = '0; b4.s_cyc = 1'b0;
    tick();

    // Asynchronous reset in the middle of a busy cycle
    b4.s_addr = 16'h8000; b4.s_we = 1'b1; b4.s_cyc = 1'b1;
    tick(); tick();
    chk("rb_busy_m_cyc", 64'(b4.m_cyc), 64'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_m_cyc", 64'(b4.m_cyc), 64'h0);
    chk("ra_m_addr", 64'(b4.m_addr), 64'h0);
    chk("ra_m_we", 64'(b4.m_we), 64'h0);
    chk("ra_s_ack", 64'(b4.s_ack), 64'h0);
    b4.s_cyc = 1'b0; b4.s_we = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("ra_no_stale_ack", 64'(b4.s_ack), 64'h0);
    tick();
    chk("ra_no_stale_ack2", 64'(b4.s_ack), 64'h0);
    b4.s_addr = 16'hC010; b4.s_cyc = 1'b1;
    tick();                                            // t+1
    chk("ra_fresh_m_cyc", 64'(b4.m_cyc), 64'h8);
    b4.m_ack = 4'b1000; b4.m_rdata[96 +: 32] = 32'h5A5A1234;
    tick();
    chk("ra_fresh_data", 64'(b4.s_rdata), 64'h5A5A1234);
    chk("ra_fresh_err", 64'(b4.s_err), 64'h0);
    b4.m_ack = '0; b4.s_cyc = 1'b0;
    tick();

    chk("um_m_cyc_never", 64'(b3_cyc_seen), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
